// File: rtl/i2c_slave_regs.sv
// I2C target with an 8-bit register pointer and a strobe-based register bank port.
// Decodes device and register address bytes, then performs burst writes and reads.
module i2c_slave_regs #(
  parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       SCL,
  inout  wire        SDA,
  output logic [7:0] o_reg_addr,
  output logic [7:0] o_wdata,
  output logic       o_wr_en,
  output logic       o_rd_en,
  input  logic [7:0] i_rdata,
  output logic       o_busy
);

  typedef enum logic [3:0] {
    IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_t;

  state_t     state, state_nxt;
  logic       scl_p0, scl_p1, scl_p2;
  logic       sda_p0, sda_p1, sda_p2;
  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [3:0] bit_cnt, bit_cnt_nxt;
  logic [7:0] shift, shift_nxt;
  logic [7:0] ptr_nxt, wdata_nxt;
  logic       sda_low, sda_low_nxt;
  logic       wr_nxt, rd_nxt, busy_nxt;
  logic       rw, rw_nxt, rd_ack, rd_ack_nxt;

  // Open-drain: only ever pull low or let the bus float high.
  assign SDA = sda_low ? 1'b0 : 1'bz;

  // p0/p1 form the synchronizer, p2 is the history stage for edge detection
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      scl_p0 <= 1'b1;
      scl_p1 <= 1'b1;
      scl_p2 <= 1'b1;
      sda_p0 <= 1'b1;
      sda_p1 <= 1'b1;
      sda_p2 <= 1'b1;
    end else begin
      scl_p0 <= SCL;
      scl_p1 <= scl_p0;
      scl_p2 <= scl_p1;
      sda_p0 <= SDA;
      sda_p1 <= sda_p0;
      sda_p2 <= sda_p1;
    end
  end

  assign scl_rise  = scl_p1 & ~scl_p2;
  assign scl_fall  = ~scl_p1 & scl_p2;
  assign start_det = scl_p1 & scl_p2 & sda_p2 & ~sda_p1;
  assign stop_det  = scl_p1 & scl_p2 & ~sda_p2 & sda_p1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      bit_cnt    <= 4'd0;
      sda_low    <= 1'b0;
      o_reg_addr <= 8'd0;
      o_wdata    <= 8'd0;
      o_wr_en    <= 1'b0;
      o_rd_en    <= 1'b0;
      o_busy     <= 1'b0;
      rw         <= 1'b0;
      rd_ack     <= 1'b0;
    end else begin
      state      <= state_nxt;
      bit_cnt    <= bit_cnt_nxt;
      sda_low    <= sda_low_nxt;
      o_reg_addr <= ptr_nxt;
      o_wdata    <= wdata_nxt;
      o_wr_en    <= wr_nxt;
      o_rd_en    <= rd_nxt;
      o_busy     <= busy_nxt;
      rw         <= rw_nxt;
      rd_ack     <= rd_ack_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    shift <= shift_nxt;
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift;
    // The write strobe's address is held for its cycle; the pointer advances right after.
    ptr_nxt     = o_wr_en ? o_reg_addr + 8'd1 : o_reg_addr;
    wdata_nxt   = o_wdata;
    sda_low_nxt = sda_low;
    wr_nxt      = 1'b0;
    rd_nxt      = 1'b0;
    busy_nxt    = o_busy;
    rw_nxt      = rw;
    rd_ack_nxt  = rd_ack;

    if (start_det) begin
      state_nxt   = DEV_ADDR;
      bit_cnt_nxt = 4'd0;
      sda_low_nxt = 1'b0;
    end else if (stop_det) begin
      state_nxt   = IDLE;
      sda_low_nxt = 1'b0;
      busy_nxt    = 1'b0;
    end else begin
      case (state)
        DEV_ADDR: begin
          if (scl_rise) begin
            shift_nxt   = {shift[6:0], sda_p1};
            bit_cnt_nxt = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            if (shift[7:1] == SLAVE_ADDR) begin
              sda_low_nxt = 1'b1;
              rw_nxt      = shift[0];
              busy_nxt    = 1'b1;
              state_nxt   = DEV_ACK;
            end else begin
              sda_low_nxt = 1'b0;
              busy_nxt    = 1'b0;
              state_nxt   = IDLE;
            end
          end
        end
        DEV_ACK: begin
          if (scl_fall) begin
            bit_cnt_nxt = 4'd0;
            if (rw) begin
              shift_nxt   = i_rdata;
              rd_nxt      = 1'b1;
              sda_low_nxt = ~i_rdata[7];
              state_nxt   = RDATA;
            end else begin
              sda_low_nxt = 1'b0;
              state_nxt   = REG_ADDR;
            end
          end
        end
        REG_ADDR: begin
          if (scl_rise) begin
            shift_nxt   = {shift[6:0], sda_p1};
            bit_cnt_nxt = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            ptr_nxt     = shift;
            sda_low_nxt = 1'b1;
            state_nxt   = REG_ACK;
          end
        end
        REG_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            sda_low_nxt = 1'b0;
            bit_cnt_nxt = 4'd0;
            state_nxt   = WDATA;
          end
        end
        WDATA: begin
          if (scl_rise) begin
            shift_nxt   = {shift[6:0], sda_p1};
            bit_cnt_nxt = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            wdata_nxt   = shift;
            wr_nxt      = 1'b1;
            sda_low_nxt = 1'b1;
            state_nxt   = WDATA_ACK;
          end
        end
        RDATA: begin
          if (scl_rise) begin
            bit_cnt_nxt = bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_low_nxt = 1'b0;
              rd_ack_nxt  = 1'b0;
              state_nxt   = RDATA_ACK;
            end else begin
              shift_nxt   = {shift[6:0], 1'b0};
              sda_low_nxt = ~shift[6];
            end
          end
        end
        RDATA_ACK: begin
          if (scl_rise) begin
            if (!sda_p1) begin
              ptr_nxt    = o_reg_addr + 8'd1;
              rd_ack_nxt = 1'b1;
            end else begin
              sda_low_nxt = 1'b0;
              busy_nxt    = 1'b0;
              state_nxt   = IDLE;
            end
          end else if (scl_fall && rd_ack) begin
            rd_ack_nxt  = 1'b0;
            shift_nxt   = i_rdata;
            rd_nxt      = 1'b1;
            sda_low_nxt = ~i_rdata[7];
            bit_cnt_nxt = 4'd0;
            state_nxt   = RDATA;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
